// File: rtl/inst_pkg.sv
// Shared instruction-format definitions for the instruction writer and reader.
// Field layout: opcode [15:12], buf_id [11:10], mem_loc [9:0].
package inst_pkg;

  localparam int INST_WIDTH     = 16;
  localparam int OPCODE_WIDTH   = 4;
  localparam int BUF_ID_WIDTH   = 2;
  localparam int MEM_LOC_WIDTH  = 10;
  localparam int TILE_CNT_WIDTH = 8;

  localparam int OPCODE_LSB  = 12;
  localparam int BUF_ID_LSB  = 10;
  localparam int MEM_LOC_LSB = 0;

  localparam logic [OPCODE_WIDTH-1:0] OP_LD       = 4'b0010;
  localparam logic [OPCODE_WIDTH-1:0] OP_ST       = 4'b0011;
  localparam logic [OPCODE_WIDTH-1:0] OP_GEMM     = 4'b0100;
  localparam logic [OPCODE_WIDTH-1:0] OP_DRAINSYS = 4'b0101;

  localparam logic [BUF_ID_WIDTH-1:0] BUF_A = 2'd0;
  localparam logic [BUF_ID_WIDTH-1:0] BUF_B = 2'd1;
  localparam logic [BUF_ID_WIDTH-1:0] BUF_C = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_A,
    S_LD_B,
    S_GEMM,
    S_DRAIN,
    S_ST,
    S_DONE
  } state_e;

endpackage

// File: rtl/inst_encoder.sv
// Combinational packer: opcode / buf_id / mem_loc into one instruction word.
module inst_encoder
  import inst_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0]  opcode_i,
  input  logic [BUF_ID_WIDTH-1:0]  buf_id_i,
  input  logic [MEM_LOC_WIDTH-1:0] mem_loc_i,
  output logic [INST_WIDTH-1:0]    inst_o
);

  always_comb begin
    inst_o = '0;
    inst_o[OPCODE_LSB  +: OPCODE_WIDTH]  = opcode_i;
    inst_o[BUF_ID_LSB  +: BUF_ID_WIDTH]  = buf_id_i;
    inst_o[MEM_LOC_LSB +: MEM_LOC_WIDTH] = mem_loc_i;
  end

endmodule

// File: rtl/inst_writer.sv
// Per-tile instruction sequencer (LD A, LD B, GEMM, [DRAINSYS], ST C) with valid/ready output.
// Define INST_WRITER_DRAIN_EN to include the DRAINSYS step after each GEMM.
module inst_writer
  import inst_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [TILE_CNT_WIDTH-1:0] num_tiles,
  input  logic [MEM_LOC_WIDTH-1:0]  base_a,
  input  logic [MEM_LOC_WIDTH-1:0]  base_b,
  input  logic [MEM_LOC_WIDTH-1:0]  base_c,
  input  logic [MEM_LOC_WIDTH-1:0]  stride,
  output logic [INST_WIDTH-1:0]     inst,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic                      busy,
  output logic                      done,
  output logic [TILE_CNT_WIDTH-1:0] tile_idx
);

  state_e                    state_q, state_d;
  logic [TILE_CNT_WIDTH-1:0] tile_idx_q, tile_idx_d;
  logic [TILE_CNT_WIDTH-1:0] num_tiles_q, num_tiles_d;
  logic [MEM_LOC_WIDTH-1:0]  addr_a_q, addr_a_d;
  logic [MEM_LOC_WIDTH-1:0]  addr_b_q, addr_b_d;
  logic [MEM_LOC_WIDTH-1:0]  addr_c_q, addr_c_d;
  logic [MEM_LOC_WIDTH-1:0]  stride_q, stride_d;
  logic [INST_WIDTH-1:0]     inst_q, inst_d;
  logic                      inst_valid_q, inst_valid_d;

  logic                      hs;
  logic                      last_tile;
  logic                      emit;
  logic [OPCODE_WIDTH-1:0]   op_sel;
  logic [BUF_ID_WIDTH-1:0]   buf_sel;
  logic [MEM_LOC_WIDTH-1:0]  loc_sel;
  logic [INST_WIDTH-1:0]     enc_inst;

  assign hs        = inst_valid_q && inst_ready;
  assign last_tile = (tile_idx_q == (num_tiles_q - TILE_CNT_WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    tile_idx_d  = tile_idx_q;
    num_tiles_d = num_tiles_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    addr_c_d    = addr_c_q;
    stride_d    = stride_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_tiles_d = num_tiles;
          stride_d    = stride;
          addr_a_d    = base_a;
          addr_b_d    = base_b;
          addr_c_d    = base_c;
          tile_idx_d  = '0;
          state_d     = (num_tiles == '0) ? S_DONE : S_LD_A;
        end
      end
      S_LD_A: if (hs) state_d = S_LD_B;
      S_LD_B: if (hs) state_d = S_GEMM;
`ifdef INST_WRITER_DRAIN_EN
      S_GEMM: if (hs) state_d = S_DRAIN;
`else
      S_GEMM: if (hs) state_d = S_ST;
`endif
      S_DRAIN: if (hs) state_d = S_ST;
      S_ST: begin
        if (hs) begin
          // Addresses wrap modulo 2^MEM_LOC_WIDTH; the carry is dropped on purpose.
          addr_a_d = addr_a_q + stride_q;
          addr_b_d = addr_b_q + stride_q;
          addr_c_d = addr_c_q + stride_q;
          if (last_tile) begin
            state_d = S_DONE;
          end else begin
            tile_idx_d = tile_idx_q + TILE_CNT_WIDTH'(1);
            state_d    = S_LD_A;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The instruction register is loaded with the word for the state being entered,
  // so it stays unchanged while a handshake is pending.
  always_comb begin
    op_sel  = OP_LD;
    buf_sel = BUF_A;
    loc_sel = '0;
    emit    = 1'b1;
    case (state_d)
      S_LD_A:  loc_sel = addr_a_d;
      S_LD_B: begin
        buf_sel = BUF_B;
        loc_sel = addr_b_d;
      end
      S_GEMM: begin
        op_sel  = OP_GEMM;
        buf_sel = BUF_C;
      end
      S_DRAIN: begin
        op_sel  = OP_DRAINSYS;
        buf_sel = BUF_C;
      end
      S_ST: begin
        op_sel  = OP_ST;
        buf_sel = BUF_C;
        loc_sel = addr_c_d;
      end
      default: emit = 1'b0;
    endcase
    inst_d       = emit ? enc_inst : '0;
    inst_valid_d = emit;
  end

  inst_encoder u_encoder (
    .opcode_i  (op_sel),
    .buf_id_i  (buf_sel),
    .mem_loc_i (loc_sel),
    .inst_o    (enc_inst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tile_idx_q   <= '0;
      num_tiles_q  <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      addr_c_q     <= '0;
      stride_q     <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_idx_q   <= tile_idx_d;
      num_tiles_q  <= num_tiles_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      addr_c_q     <= addr_c_d;
      stride_q     <= stride_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign tile_idx   = tile_idx_q;

endmodule

// File: tb/tb_inst_writer.sv
// Scoreboard bench for inst_writer: expected instruction stream queued at start, checked per handshake.
module tb_inst_writer;

`ifdef INST_WRITER_DRAIN_EN
  localparam int IPT = 5;
`else
  localparam int IPT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_tiles;
  logic [9:0]  base_a, base_b, base_c, stride;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        busy;
  logic        done;
  logic [7:0]  tile_idx;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] inst;
    logic [7:0]  tile;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  inst_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_tiles  (num_tiles),
    .base_a     (base_a),
    .base_b     (base_b),
    .base_c     (base_c),
    .stride     (stride),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .busy       (busy),
    .done       (done),
    .tile_idx   (tile_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference stream built from the instruction format directly.
  task automatic push_model(input int n, input logic [9:0] ba, input logic [9:0] bb,
                            input logic [9:0] bc, input logic [9:0] st);
    logic [9:0] a, b, c;
    a = ba;
    b = bb;
    c = bc;
    for (int t = 0; t < n; t++) begin
      exp_q.push_back({4'b0010, 2'd0, a, 8'(t)});
      exp_q.push_back({4'b0010, 2'd1, b, 8'(t)});
      exp_q.push_back({4'b0100, 2'd2, 10'd0, 8'(t)});
`ifdef INST_WRITER_DRAIN_EN
      exp_q.push_back({4'b0101, 2'd2, 10'd0, 8'(t)});
`endif
      exp_q.push_back({4'b0011, 2'd2, c, 8'(t)});
      a = a + st;
      b = b + st;
      c = c + st;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra", {16'h0, inst}, 32'hDEAD_BEEF);
      end else begin
        mon_e = exp_q.pop_front();
        $display("xfer tile=%0d inst=%04h expected=%04h", tile_idx, inst, mon_e.inst);
        chk("sb_inst", {16'h0, inst}, {16'h0, mon_e.inst});
        chk("sb_tile", {24'h0, tile_idx}, {24'h0, mon_e.tile});
      end
    end
  end

  task automatic drive_cfg(input int n, input logic [9:0] ba, input logic [9:0] bb,
                           input logic [9:0] bc, input logic [9:0] st);
    num_tiles = 8'(n);
    base_a    = ba;
    base_b    = bb;
    base_c    = bc;
    stride    = st;
  endtask

  // Runs one sequence; ready is dropped for stall_len cycles from stall_c,
  // and a stray start is pulsed on cycle junk_c (0 = none).
  task automatic run_seq(input string name, input int n, input logic [9:0] ba, input logic [9:0] bb,
                         input logic [9:0] bc, input logic [9:0] st,
                         input int stall_c, input int stall_len, input int junk_c,
                         input int exp_done_c);
    bit seen;
    int done_c;
    bit stalled;
    seen   = 1'b0;
    done_c = 0;
    push_model(n, ba, bb, bc, st);
    @(posedge clk); #1;
    drive_cfg(n, ba, bb, bc, st);
    start      = 1'b1;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_cfg(int'($urandom_range(0, 255)), 10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
    for (int c = 1; c <= 300 && !seen; c++) begin
      stalled    = (stall_len > 0) && (c >= stall_c) && (c < stall_c + stall_len);
      inst_ready = !stalled;
      start      = (c == junk_c);
      if (c == junk_c) drive_cfg(7, 10'h3FF, 10'h3FF, 10'h3FF, 10'h001);
      @(negedge clk);
      if (c == 1 && n > 0) chk({name, "_first_valid"}, {31'h0, inst_valid}, 32'h1);
      if (n == 0) chk({name, "_zero_no_valid"}, {31'h0, inst_valid}, 32'h0);
      if (stalled) begin
        chk({name, "_bp_inst"}, {16'h0, inst}, 32'h4800);
        chk({name, "_bp_valid"}, {31'h0, inst_valid}, 32'h1);
      end
      if (done) begin
        seen   = 1'b1;
        done_c = c;
        chk({name, "_done_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({name, "_done_busy"}, {31'h0, busy}, 32'h1);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, {31'h0, seen}, 32'h1);
    chk({name, "_done_cycle"}, done_c, exp_done_c);
    chk({name, "_idle_busy"}, {31'h0, busy}, 32'h0);
    chk({name, "_idle_done"}, {31'h0, done}, 32'h0);
    chk({name, "_sb_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    inst_ready = 1'b0;
    drive_cfg(0, 10'h0, 10'h0, 10'h0, 10'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_inst", {16'h0, inst}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_tile", {24'h0, tile_idx}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_seq("two_tiles", 2, 10'h010, 10'h100, 10'h200, 10'h020, 0, 0, 0, 2 * IPT + 1);
    run_seq("wrap", 2, 10'h3F0, 10'h100, 10'h200, 10'h020, 0, 0, 0, 2 * IPT + 1);
    run_seq("backpressure", 2, 10'h010, 10'h100, 10'h200, 10'h020, 3, 3, 0, 2 * IPT + 4);
    run_seq("zero", 0, 10'h010, 10'h100, 10'h200, 10'h020, 0, 0, 0, 1);
    run_seq("busy_start", 2, 10'h010, 10'h100, 10'h200, 10'h020, 0, 0, 4, 2 * IPT + 1);
    run_seq("three_tiles", 3, 10'h055, 10'h2AA, 10'h3FF, 10'h101, 0, 0, 0, 3 * IPT + 1);

    // Reset during LD_B of tile 1.
    push_model(2, 10'h010, 10'h100, 10'h200, 10'h020);
    @(posedge clk); #1;
    drive_cfg(2, 10'h010, 10'h100, 10'h200, 10'h020);
    start      = 1'b1;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= IPT + 1; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_pre_tile", {24'h0, tile_idx}, 32'h1);
    chk("rst_pre_inst", {16'h0, inst}, 32'h2520);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_tile", {24'h0, tile_idx}, 32'h0);
    chk("rst_mid_inst", {16'h0, inst}, 32'h0);
    chk("rst_mid_done", {31'h0, done}, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_seq("after_rst", 1, 10'h010, 10'h100, 10'h200, 10'h020, 0, 0, 0, IPT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_writer.md
# inst_writer

Instruction writer for the systolic-array datapath: generates the per-tile instruction stream LD A, LD B, GEMM, DRAINSYS, ST C for a programmed number of tiles. Packs each instruction into the 16-bit opcode/buf_id/mem_loc format consumed by the instruction reader. Delivers instructions over a valid/ready handshake. Sits between the host-side configuration registers and the instruction reader.

## Interface
- INST_WIDTH, 16, instruction width
- OPCODE_WIDTH, 4, opcode field, bits [15:12]
- BUF_ID_WIDTH, 2, buffer-id field, bits [11:10]
- MEM_LOC_WIDTH, 10, memory-location field, bits [9:0]
- TILE_CNT_WIDTH, 8, tile counter width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- num_tiles  in  TILE_CNT_WIDTH  tile count, latched at start
- base_a / base_b / base_c  in  MEM_LOC_WIDTH  first-tile addresses, latched at start
- stride  in  MEM_LOC_WIDTH  per-tile address increment, latched at start
- inst  out  INST_WIDTH  packed instruction (registered)
- inst_valid  out  1  inst holds a valid instruction (registered)
- inst_ready  in  1  reader accepts inst this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at sequence end
- tile_idx  out  TILE_CNT_WIDTH  index of tile being issued

## Operation
- Opcodes: LD=4'b0010, ST=4'b0011, GEMM=4'b0100, DRAINSYS=4'b0101.
- Buffer ids: BUF_A=0, BUF_B=1, BUF_C=2.
- Per tile, in order:
  - LD BUF_A at addr_a
  - LD BUF_B at addr_b
  - GEMM BUF_C, mem_loc 0
  - DRAINSYS BUF_C, mem_loc 0
  - ST BUF_C at addr_c
- FSM states: IDLE, LD_A, LD_B, GEMM, DRAIN, ST, DONE.
  - An emit state advances only on inst_valid && inst_ready.
  - ST handshake with tile_idx < num_tiles-1: increment tile_idx, go to LD_A.
  - ST handshake on the last tile: go to DONE.
  - DONE lasts one cycle, then IDLE.
- On start in IDLE:
  - Latch config.
  - Load addr_a/b/c from base_a/b/c.
  - Set tile_idx=0.
  - num_tiles==0: go to DONE directly; no instruction is issued.
- After each ST handshake, addr_a/b/c each += stride, modulo 2^MEM_LOC_WIDTH (carry discarded, wraps silently).
- start while busy is ignored. Config inputs are don't-care outside the start cycle.

## Timing
- Reset values: inst=0, inst_valid=0, busy=0, done=0, tile_idx=0, state=IDLE, addresses 0.
- Start at cycle 0: busy=1 and inst_valid=1 with the first LD at cycle 1.
- Throughput: one instruction per cycle while inst_ready is held high.
- Once inst_valid is asserted, inst is stable and valid is not retracted until the handshake.
- After the last ST handshake at cycle k:
  - Cycle k+1: inst_valid=0, done=1, busy=1.
  - Cycle k+2: back in IDLE; start is accepted here.
- rst mid-sequence: all outputs clear immediately (asynchronous). No partial instruction is held. The next start begins a fresh sequence.

## Configuration
- INST_WRITER_DRAIN_EN defined: DRAIN state present; 5 instructions per tile.
- INST_WRITER_DRAIN_EN undefined: GEMM proceeds directly to ST; 4 instructions per tile; DRAINSYS is never emitted.

## Structure
- Shared package inst_pkg holds:
  - width parameters and field bit indices
  - opcode constants
  - BUF_A/BUF_B/BUF_C constants
  - state enum typedef
- The reader and the writer both import inst_pkg.
- Sub-module inst_encoder: combinational pack of opcode/buf_id/mem_loc into INST_WIDTH. Its output is registered in inst_writer.

## Test plan
- Two tiles with DRAIN_EN:
  - Stimulus: num_tiles=2, base_a=0x010, base_b=0x100, base_c=0x200, stride=0x020, ready=1.
  - Response: 0x2010, 0x2500, 0x4800, 0x5800, 0x3A00, 0x2030, 0x2520, 0x4800, 0x5800, 0x3A20 on cycles 1–10; done on cycle 11.
- Address wrap:
  - Stimulus: base_a=0x3F0, stride=0x020, num_tiles=2.
  - Response: second LD A is 0x2010.
- Backpressure:
  - Stimulus: ready low for 3 cycles during GEMM.
  - Response: inst=0x4800 and inst_valid=1 held stable for all 3 cycles; DRAIN follows the cycle after ready rises.
- Zero tiles / start while busy:
  - Stimulus: num_tiles=0.
  - Response: done on cycle 1, inst_valid never asserted.
  - Stimulus: start pulsed while busy.
  - Response: no effect on the sequence.
- Reset mid-operation:
  - Stimulus: rst asserted during LD_B of tile 1.
  - Response: inst_valid, busy and tile_idx are 0 before the next edge. A new start then emits 0x2010 first.
- DRAIN_EN undefined:
  - Stimulus: same config as the two-tile case.
  - Response: 8 instructions with no 0x5800; done on cycle 9.
